uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Byte-level command parser between the UART receiver/transmitter and the HBM traffic-generator control logic inside the top-level design.
- Consumes received bytes, decodes write/read commands and maintains a bank of 32-bit control registers that drive the traffic generators.
- Returns acknowledge, error or read-data bytes to the UART transmitter through a valid/ready handshake.

Parameters:
- NUM_REGS, 8, number of 32-bit writable control registers; legal addresses are 0x00..NUM_REGS-1 (max 64).
- STATUS_ADDR, 8'h80, read-only address that returns status_in.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one command before the command is abandoned.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe: rx_data is valid.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid; held until accepted.
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
- regs_out  output  NUM_REGS*32  control registers, reg i at bits [32*i+31:32*i].
- wr_strobe  output  NUM_REGS  one-cycle pulse on the bit of the register just written.
- status_in  input  32  live status word, sampled when a status read executes.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE, all regs_out=0, wr_strobe=0, tx_valid=0, tx_data=0, busy=0, timeout counter=0. Reset mid-command or mid-response abandons it; no partial register write.
- Command formats, bytes MSB first:
  - Write: 'W'(0x57), addr, d3, d2, d1, d0.
  - Read: 'R'(0x52), addr.
- FSM states: IDLE, GET_ADDR, GET_DATA (2-bit byte index), [GET_CSUM], EXEC, SEND (byte index, count 1 or 4).
- IDLE:
  - 'W' or 'R' goes to GET_ADDR.
  - Any other byte loads tx_data=0x45 ('E') and goes to SEND with count 1.
- GET_ADDR: a 'W' goes to GET_DATA; an 'R' goes to EXEC (or GET_CSUM if the optional feature is enabled).
- GET_DATA: shifts in 4 bytes, then goes to EXEC (or GET_CSUM).
- EXEC (exactly one cycle):
  - Write to addr<NUM_REGS: updates the register, pulses the matching wr_strobe bit, responds 'K'(0x4B).
  - Write to STATUS_ADDR or any other address: no write, responds 'E'.
  - Read of addr<NUM_REGS: responds with that register, 4 bytes MSB first.
  - Read of STATUS_ADDR: captures status_in in this cycle and responds with it, 4 bytes.
  - Read of any other address: responds 'E'.
- Latency: the last command byte is accepted in cycle N. EXEC runs in cycle N+1, with the register update and wr_strobe in that cycle. tx_valid rises in cycle N+2.
- SEND:
  - tx_data stays stable while tx_valid && !tx_ready.
  - On each handshake, the next byte is presented in the following cycle with no gap.
  - After the final handshake, go to IDLE with tx_valid=0.
- Bytes arriving in EXEC or SEND are discarded; the host must wait for the response.
- Timeout:
  - The counter clears on every accepted byte and counts in GET_ADDR/GET_DATA/GET_CSUM.
  - On reaching TIMEOUT_CYCLES-1, go to IDLE with no response and no write.
  - If a byte arrives in that same cycle, the byte wins and the timeout does not fire.
  - The counter does not run in IDLE, EXEC or SEND.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- Defined:
  - Every command carries one trailing byte equal to the XOR of all preceding command bytes, received in GET_CSUM.
  - On a mismatch, EXEC performs no write or read and responds 'C'(0x43).
  - The timeout also applies in GET_CSUM.
- Undefined: the GET_CSUM state and its logic are not built, and commands have no checksum byte.

Test Plan:
- rst pulse mid-write (after 'W',0x02,0xAA) -> regs_out all 0, tx_valid=0, busy=0. The next full write 'W',0x02,0x11,0x22,0x33,0x44 -> reg2=0x11223344, wr_strobe=0x04 for one cycle, 'K' sent.
- 'R',0x02 with tx_ready low for 5 cycles between bytes -> bytes 0x11,0x22,0x33,0x44 in order, tx_data stable while stalled.
- 'R',0x80 with status_in=0xDEADBEEF -> 0xDE,0xAD,0xBE,0xEF. 'W',0x80,... -> 'E', no wr_strobe. 'R',0x09 with NUM_REGS=8 -> 'E'. Stray byte 0x41 in IDLE -> 'E'.
- TIMEOUT_CYCLES=16: send 'W',0x01 then stall 16 cycles -> return to IDLE, no response. Then 'R',0x01 -> 0x00000000.
- A byte arriving in the timeout-limit cycle is accepted; bytes sent during SEND are ignored, and the response is unchanged.
- With CMD_CHECKSUM_EN: 'W',0x01,0x00,0x00,0x00,0x05,0x53 -> write, 'K'. The same command with checksum 0x00 -> 'C', reg1 unchanged.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: byte-level W/R command decoder driving a bank of 32-bit
// control registers, replying to the UART transmitter over valid/ready.
// Optional trailing XOR checksum byte is enabled by defining CMD_CHECKSUM_EN.
module uart_cmd_parser #(
  parameter int         NUM_REGS       = 8,
  parameter logic [7:0] STATUS_ADDR    = 8'h80,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_strobe,
  input  logic [31:0]              status_in,
  output logic                     busy
);

  localparam int             AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     NREGS8   = 8'(NUM_REGS);
  localparam logic [7:0]     CH_W = 8'h57, CH_R = 8'h52, CH_E = 8'h45, CH_K = 8'h4B;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef CMD_CHECKSUM_EN
    GET_CSUM,
`endif
    EXEC,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [23:0]   resp_q, resp_d;
  logic [1:0]    rem_q, rem_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          csum_ok_q, csum_ok_d;
`endif

  logic [31:0]   regs_q [NUM_REGS];
  logic [AW-1:0] ridx;
  logic          legal, wr_en, in_get, tmo_hit;
  logic [31:0]   rd_word;
  state_t        after_payload;

  assign ridx     = addr_q[AW-1:0];
  assign legal    = addr_q < NREGS8;
  assign rd_word  = regs_q[ridx];
  assign tmo_hit  = tmo_q == TMO_LAST;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = state_q != IDLE;
`ifdef CMD_CHECKSUM_EN
  assign in_get        = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CSUM);
  assign after_payload = GET_CSUM;
`else
  assign in_get        = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign after_payload = EXEC;
`endif

  // Flatten register bank and decode the one-hot write strobe
  always_comb begin
    regs_out  = '0;
    wr_strobe = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[32*i +: 32] = regs_q[i];
      wr_strobe[i]         = wr_en && (ridx == AW'(i));
    end
  end

  // Next-state, response and timeout logic
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    resp_d     = resp_q;
    rem_d      = rem_q;
    wr_en      = 1'b0;
`ifdef CMD_CHECKSUM_EN
    csum_d     = csum_q;
    csum_ok_d  = csum_ok_q;
`endif
    // A byte in the limit cycle takes priority over the timeout
    if (in_get && !rx_valid && !tmo_hit) tmo_d = tmo_q + 1'b1;

    case (state_q)
      IDLE: if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
        csum_d = rx_data;
`endif
        if (rx_data == CH_W || rx_data == CH_R) begin
          is_wr_d = rx_data == CH_W;
          state_d = GET_ADDR;
        end else begin
          tx_data_d  = CH_E;
          tx_valid_d = 1'b1;
          rem_d      = '0;
          state_d    = SEND;
        end
      end
      GET_ADDR: if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        addr_d  = rx_data;
        idx_d   = '0;
        state_d = is_wr_q ? GET_DATA : after_payload;
      end else if (tmo_hit) begin
        state_d = IDLE;
      end
      GET_DATA: if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        data_d = {data_q[23:0], rx_data};
        idx_d  = idx_q + 1'b1;
        if (idx_q == 2'd3) state_d = after_payload;
      end else if (tmo_hit) begin
        state_d = IDLE;
      end
`ifdef CMD_CHECKSUM_EN
      GET_CSUM: if (rx_valid) begin
        csum_ok_d = rx_data == csum_q;
        state_d   = EXEC;
      end else if (tmo_hit) begin
        state_d = IDLE;
      end
`endif
      EXEC: begin
        state_d    = SEND;
        tx_valid_d = 1'b1;
        rem_d      = '0;
        tx_data_d  = CH_E;
`ifdef CMD_CHECKSUM_EN
        if (!csum_ok_q) tx_data_d = 8'h43;
        else
`endif
        if (is_wr_q) begin
          if (legal) begin
            wr_en     = 1'b1;
            tx_data_d = CH_K;
          end
        end else if (legal) begin
          tx_data_d = rd_word[31:24];
          resp_d    = rd_word[23:0];
          rem_d     = 2'd3;
        end else if (addr_q == STATUS_ADDR) begin
          tx_data_d = status_in[31:24];
          resp_d    = status_in[23:0];
          rem_d     = 2'd3;
        end
      end
      SEND: if (tx_ready) begin
        if (rem_q == '0) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tx_data_d = resp_q[23:16];
          resp_d    = {resp_q[15:0], 8'h00};
          rem_d     = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      resp_q     <= '0;
      rem_q      <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= '0;
      csum_ok_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      resp_q     <= resp_d;
      rem_q      <= rem_d;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_ok_q  <= csum_ok_d;
`endif
    end
  end

  // Control register bank, written only from EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ridx] <= data_q;
    end
  end

endmodule
